// File: rtl/game_flow_ctrl.sv
// Game-level sequencer for the racing datapath: paces datapath updates per frame,
// gates steering, and runs the start/countdown/run/pause/crash/over flow with lives.
module game_flow_ctrl #(
  parameter int unsigned LIVES            = 3,
  parameter int unsigned COUNTDOWN_FRAMES = 120,
  parameter int unsigned CRASH_FRAMES     = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic [1:0]  control_in,
  input  logic        colisao,
  input  logic        opp_wrap,
  output logic        step_en,
  output logic [1:0]  control_out,
  output logic        dp_reset,
  output logic [1:0]  lives,
  output logic [15:0] passes,
  output logic [2:0]  state,
  output logic        game_over
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned PASS_W  = 16;
  localparam int unsigned CTL_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_CRASH     = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [LIVES_W-1:0]  r_lives;
  logic [LIVES_W-1:0]  w_lives_next;
  logic [PASS_W-1:0]   r_passes;
  logic [PASS_W-1:0]   w_passes_next;
  logic                r_pause_pend;
  logic                w_pause_pend_next;
  logic                r_step_en;
  logic                w_step_next;
  logic                r_dp_reset;
  logic                w_dp_reset_next;
  logic [CTL_W-1:0]    r_ctl_out;
  logic [CTL_W-1:0]    w_ctl_latch;
  logic [CTL_W-1:0]    w_ctl_next;
  logic                r_game_over;

  logic                r_start_s1, r_start_s2, r_start_d, r_start_edge;
  logic                r_pause_s1, r_pause_s2, r_pause_d, r_pause_edge;
  logic [CTL_W-1:0]    r_ctl_s1, r_ctl_s2;
  logic                w_pause_req;

  // Synchronizers and registered edge detect; the edge is consumed one cycle after detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_d    <= 1'b0;
      r_start_edge <= 1'b0;
      r_pause_s1   <= 1'b0;
      r_pause_s2   <= 1'b0;
      r_pause_d    <= 1'b0;
      r_pause_edge <= 1'b0;
      r_ctl_s1     <= '0;
      r_ctl_s2     <= '0;
    end else begin
      r_start_s1   <= btn_start;
      r_start_s2   <= r_start_s1;
      r_start_d    <= r_start_s2;
      r_start_edge <= r_start_s2 & ~r_start_d;
      r_pause_s1   <= btn_pause;
      r_pause_s2   <= r_pause_s1;
      r_pause_d    <= r_pause_s2;
      r_pause_edge <= r_pause_s2 & ~r_pause_d;
      r_ctl_s1     <= control_in;
      r_ctl_s2     <= r_ctl_s1;
    end
  end

  assign w_pause_req = r_pause_pend | r_pause_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lives      <= '0;
      r_passes     <= '0;
      r_pause_pend <= 1'b0;
      r_step_en    <= 1'b0;
      r_dp_reset   <= 1'b1;
      r_ctl_out    <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_lives      <= w_lives_next;
      r_passes     <= w_passes_next;
      r_pause_pend <= w_pause_pend_next;
      r_step_en    <= w_step_next;
      r_dp_reset   <= w_dp_reset_next;
      r_ctl_out    <= w_ctl_next;
      r_game_over  <= (w_state_next == S_OVER);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_lives_next      = r_lives;
    w_passes_next     = r_passes;
    w_pause_pend_next = 1'b0;
    w_step_next       = 1'b0;
    w_dp_reset_next   = 1'b0;
    w_ctl_latch       = r_ctl_out;
    w_ctl_next        = '0;

    case (r_state)
      S_IDLE: begin
        if (r_start_edge) begin
          w_state_next  = S_COUNTDOWN;
          w_lives_next  = LIVES_W'(LIVES);
          w_passes_next = '0;
          w_cnt_next    = '0;
        end
      end
      S_COUNTDOWN: begin
        if (frame_start) begin
          if (r_cnt == CNT_W'(COUNTDOWN_FRAMES - 1)) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        w_pause_pend_next = w_pause_req;
        if (opp_wrap && (r_passes != '1)) w_passes_next = r_passes + PASS_W'(1);
        // Collision outranks a pending pause on the same frame
        if (frame_start) begin
          if (colisao) begin
            w_state_next      = S_CRASH;
            w_cnt_next        = '0;
            w_pause_pend_next = 1'b0;
            if (r_lives != '0) w_lives_next = r_lives - LIVES_W'(1);
          end else begin
            w_step_next = 1'b1;
            w_ctl_latch = r_ctl_s2;
            if (w_pause_req) begin
              w_state_next      = S_PAUSE;
              w_pause_pend_next = 1'b0;
            end
          end
        end
      end
      S_PAUSE: begin
        w_pause_pend_next = w_pause_req;
        if (frame_start && w_pause_req) begin
          w_state_next      = S_RUN;
          w_pause_pend_next = 1'b0;
        end
      end
      S_CRASH: begin
        if (frame_start) begin
          if (r_cnt == CNT_W'(CRASH_FRAMES - 1)) begin
            w_cnt_next = '0;
            if (r_lives == '0) begin
              w_state_next = S_OVER;
            end else begin
              w_state_next    = S_COUNTDOWN;
              w_dp_reset_next = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (r_start_edge) begin
          w_state_next    = S_COUNTDOWN;
          w_dp_reset_next = 1'b1;
          w_lives_next    = LIVES_W'(LIVES);
          w_passes_next   = '0;
          w_cnt_next      = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    if (w_state_next == S_IDLE) w_dp_reset_next = 1'b1;
    if (w_state_next == S_RUN)  w_ctl_next      = w_ctl_latch;
  end

  assign step_en     = r_step_en;
  assign control_out = r_ctl_out;
  assign dp_reset    = r_dp_reset;
  assign lives       = r_lives;
  assign passes      = r_passes;
  assign state       = r_state;
  assign game_over   = r_game_over;

endmodule
